infer_key_ctrl: RTL and testbench

//  Parametrised operator front-end for the MNIST inference top: debounces N active-low keys,

---
 rtl/infer_ctrl_pkg.sv | 26 ++
 rtl/key_debounce.sv | 51 +++++
 rtl/infer_key_ctrl.sv | 139 +++++++++++++
 tb/tb_infer_key_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/infer_ctrl_pkg.sv
// Shared constants for the inference operator front-end: FSM encoding, key roles,
// and counter sizing helpers.
package infer_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_SHOW  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam int KEY_START = 0;
  localparam int KEY_MODE  = 1;

  // Bit of the free-running blink counter that toggles every 2^22 cycles.
  localparam int BLINK_BIT = 22;

  // Bits needed to hold the value max_val (never less than one).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-FF synchroniser, stability counter, and a one-cycle pulse
// on each accepted press (accepted 1->0 transition).
module key_debounce
  import infer_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Idle (released) level is 1, so reset never fabricates a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_key_n;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable_d & ~r_stable;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/infer_key_ctrl.sv
// Operator front-end for the MNIST inference core: debounced keys, start/done handshake,
// timeout error and LED result display. Optional feature macro: INFER_BUSY_BLINK_EN.
module infer_key_ctrl
  import infer_ctrl_pkg::*;
#(
  parameter int N_KEYS       = 2,
  parameter int N_LEDS       = 4,
  parameter int CLASS_W      = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int TIMEOUT_CYC  = 50_000_000,
  parameter int HOLD_CYC     = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic              start_o,
  input  logic              done_i,
  input  logic [CLASS_W-1:0] class_i,
  output logic              busy_o,
  output logic              err_o,
  output logic              cont_o,
  output logic [N_KEYS-1:0] key_evt_o,
  output logic [N_LEDS-1:0] led_o
);

  localparam int            TW         = cnt_width(max_int(TIMEOUT_CYC, HOLD_CYC));
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYC - 1);

  logic [2:0]        r_state;
  logic [TW-1:0]     r_timer;
  logic              r_err;
  logic              r_cont;
  logic [N_LEDS-1:0] r_led;
  logic [N_KEYS-1:0] w_evt;
  logic [TW-1:0]     w_timer_inc;
  logic [N_LEDS-1:0] w_class_led;

  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key_n (key_n[gi]),
        .o_press (w_evt[gi])
      );
    end
  endgenerate

  // One counter serves both the WAIT timeout and the SHOW hold; it saturates.
  assign w_timer_inc = (r_timer == {TW{1'b1}}) ? r_timer : r_timer + 1'b1;
  assign w_class_led = N_LEDS'(class_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_err   <= 1'b0;
      r_cont  <= 1'b0;
      r_led   <= '0;
    end else begin
      if (w_evt[KEY_MODE]) begin
        r_cont <= ~r_cont;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_evt[KEY_START] || r_cont) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_err   <= 1'b0;
          r_timer <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the expiry cycle still counts as success.
          if (done_i) begin
            r_led   <= w_class_led;
            r_timer <= '0;
            r_state <= ST_SHOW;
          end else if (r_timer == TIMER_LAST) begin
            r_err   <= 1'b1;
            r_led   <= '1;
            r_state <= ST_ERR;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        ST_SHOW: begin
          if (!r_cont) begin
            r_state <= ST_IDLE;
          end else if (r_timer == HOLD_LAST) begin
            r_state <= ST_START;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign start_o   = (r_state == ST_START);
  assign busy_o    = (r_state == ST_START) || (r_state == ST_WAIT);
  assign err_o     = r_err;
  assign cont_o    = r_cont;
  assign key_evt_o = w_evt;

`ifdef INFER_BUSY_BLINK_EN
  logic [BLINK_BIT:0] r_blink;
  logic [N_LEDS-1:0]  w_blink_led;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink <= '0;
    end else begin
      r_blink <= r_blink + 1'b1;
    end
  end

  always_comb begin
    w_blink_led             = '0;
    w_blink_led[N_LEDS-1]   = r_blink[BLINK_BIT];
  end

  assign led_o = busy_o ? w_blink_led : r_led;
`else
  assign led_o = r_led;
`endif

endmodule

// File: tb/tb_infer_key_ctrl.sv
// Self-checking bench for infer_key_ctrl: vector table of inference runs, hand-written
// continuous-mode and reset sequences, and randomized key bouncing against a run-length model.
module tb_infer_key_ctrl;

  localparam int NK   = 3;
  localparam int NL   = 4;
  localparam int CW   = 4;
  localparam int DEB  = 4;
  localparam int TMO  = 20;
  localparam int HOLD = 8;
  localparam int RLEN = 400;
  localparam int PRESS_LEN = 10;

  typedef struct {
    int cls;
    int w;        // WAIT cycle carrying done_i (0 = never)
    int exp_led;
    int exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_n;
  logic          start_o;
  logic          done_i;
  logic [CW-1:0] class_i;
  logic          busy_o;
  logic          err_o;
  logic          cont_o;
  logic [NK-1:0] key_evt_o;
  logic [NL-1:0] led_o;

  infer_key_ctrl #(
    .N_KEYS(NK), .N_LEDS(NL), .CLASS_W(CW),
    .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TMO), .HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .start_o(start_o), .done_i(done_i),
    .class_i(class_i), .busy_o(busy_o), .err_o(err_o), .cont_o(cont_o),
    .key_evt_o(key_evt_o), .led_o(led_o)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int last_start = 0;
  int n_evt [NK];
  int key_cnt [NK];
  logic [NK-1:0] key_idle;
  logic [NK-1:0] smp_evt;
  logic [NK-1:0] exp_mask [0:RLEN+16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: sample outputs mid-cycle, then drive inputs for the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    smp_evt = key_evt_o;
    if (start_o) begin
      n_start++;
      last_start = cyc;
    end
    for (int k = 0; k < NK; k++) begin
      if (key_evt_o[k]) n_evt[k]++;
      if (key_cnt[k] > 0) begin
        // press pattern: low, one bounce high, then low
        key_n[k] = (key_cnt[k] == PRESS_LEN - 1);
        key_cnt[k]--;
      end else begin
        key_n[k] = key_idle[k];
      end
    end
    done_i  = 1'b0;
    class_i = CW'($urandom);
  endtask

  initial begin
    vec_t vecs [6];
    int base_start;
    int base_evt;
    int show_cyc;
    logic [NK-1:0] m_stable;
    logic [NK-1:0] m_run_val;
    int m_run_len [NK];

    vecs[0] = '{cls: 7, w: 5,  exp_led: 4'b0111, exp_err: 0};
    vecs[1] = '{cls: 3, w: 0,  exp_led: 4'b1111, exp_err: 1};
    vecs[2] = '{cls: 9, w: 20, exp_led: 4'b1001, exp_err: 0};
    vecs[3] = '{cls: 2, w: 1,  exp_led: 4'b0010, exp_err: 0};
    vecs[4] = '{cls: 0, w: 0,  exp_led: 4'b1111, exp_err: 1};
    vecs[5] = '{cls: 5, w: 19, exp_led: 4'b0101, exp_err: 0};

    rst_n = 1'b0; key_n = '1; key_idle = '1; done_i = 1'b0; class_i = '0;
    for (int k = 0; k < NK; k++) begin
      key_cnt[k] = 0;
      n_evt[k]   = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_start", start_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cont", cont_o, 0);
    chk("rst_evt", key_evt_o, 0);
    chk("rst_led", led_o, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("idle_no_start", n_start, 0);

    // Vector table: one key[0] press per record, done_i at a chosen WAIT cycle.
    for (int r = 0; r < 6; r++) begin
      base_start = n_start;
      base_evt   = n_evt[0];
      key_cnt[0] = PRESS_LEN;
      for (int i = 0; i < 30 && n_start == base_start; i++) tick();
      chk("vec_start_seen", n_start - base_start, 1);
      for (int i = 1; i <= 24; i++) begin
        tick();
        if (i == 1) begin
          chk("vec_busy_wait1", busy_o, 1);
          chk("vec_err_cleared", err_o, 0);
        end
        if (i == 20) chk("vec_busy_last_wait", busy_o, (vecs[r].w == 0 || vecs[r].w == 20) ? 1 : 0);
        if (i == 21) begin
          chk("vec_err_at_timeout", err_o, (vecs[r].w == 0) ? 1 : 0);
          chk("vec_busy_after", busy_o, 0);
        end
        if (i == vecs[r].w) begin
          done_i  = 1'b1;
          class_i = CW'(vecs[r].cls);
        end
      end
      chk("vec_led", led_o, vecs[r].exp_led);
      chk("vec_err", err_o, vecs[r].exp_err);
      chk("vec_one_start", n_start - base_start, 1);
      chk("vec_one_evt", n_evt[0] - base_evt, 1);
      $display("vec %0d class=%0d done_wait=%0d led=%b err=%b", r, vecs[r].cls, vecs[r].w, led_o, err_o);
    end

    // Continuous mode: two runs with an 8-cycle hold, then mode key stops after current run.
    base_start = n_start;
    key_cnt[1] = PRESS_LEN;
    for (int i = 0; i < 30 && n_start == base_start; i++) tick();
    chk("cont_start_seen", n_start - base_start, 1);
    chk("cont_on", cont_o, 1);
    tick();
    tick();
    done_i = 1'b1; class_i = 4'd3;
    tick();
    chk("cont_led_run1", led_o, 4'b0011);
    chk("cont_show_busy", busy_o, 0);
    show_cyc = cyc;
    for (int i = 0; i < 20 && n_start < base_start + 2; i++) tick();
    chk("cont_hold_gap", cyc - show_cyc, HOLD);
    key_cnt[1] = PRESS_LEN;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 14) begin
        chk("cont_run_not_aborted", busy_o, 1);
        chk("cont_off", cont_o, 0);
      end
      if (i == 15) begin
        done_i = 1'b1; class_i = 4'd9;
      end
    end
    tick();
    chk("cont_led_run2", led_o, 4'b1001);
    repeat (20) tick();
    chk("cont_stopped", n_start - base_start, 2);
    $display("cont sequence: starts=%0d led=%b cont=%b", n_start - base_start, led_o, cont_o);

    // Stray done in IDLE must not disturb the display.
    base_start = n_start;
    tick();
    done_i = 1'b1; class_i = 4'd5;
    repeat (3) tick();
    chk("stray_done_led", led_o, 4'b1001);
    chk("stray_done_busy", busy_o, 0);
    chk("stray_done_start", n_start - base_start, 0);
    $display("stray done: led=%b busy=%b", led_o, busy_o);

    // Asynchronous reset in the middle of WAIT.
    base_start = n_start;
    key_cnt[0] = PRESS_LEN;
    for (int i = 0; i < 30 && n_start == base_start; i++) tick();
    chk("rstw_start_seen", n_start - base_start, 1);
    repeat (3) tick();
    chk("rstw_busy", busy_o, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rstw_busy0", busy_o, 0);
    chk("rstw_led0", led_o, 0);
    chk("rstw_start0", start_o, 0);
    chk("rstw_err0", err_o, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    base_start = n_start;
    repeat (15) tick();
    chk("rstw_no_start", n_start - base_start, 0);
    chk("rstw_idle_busy", busy_o, 0);
    chk("rstw_idle_led", led_o, 0);
    chk("rstw_idle_cont", cont_o, 0);
    $display("reset in WAIT: busy=%b led=%b starts_after=%0d", busy_o, led_o, n_start - base_start);

    // Random bouncing: a level becomes accepted once it repeats DEB samples in a row.
    for (int t = 0; t <= RLEN + 16; t++) exp_mask[t] = '0;
    m_stable = '1;
    m_run_val = '1;
    for (int k = 0; k < NK; k++) m_run_len[k] = 100;
    for (int t = 1; t <= RLEN + 8; t++) begin
      for (int k = 0; k < NK; k++) begin
        if (t > RLEN) key_idle[k] = 1'b1;
        else if ($urandom_range(4) == 0) key_idle[k] = ~key_idle[k];
      end
      tick();
      chk("rand_key_evt", smp_evt, exp_mask[t]);
      for (int k = 0; k < NK; k++) begin
        if (key_idle[k] == m_run_val[k]) begin
          m_run_len[k]++;
        end else begin
          m_run_val[k] = key_idle[k];
          m_run_len[k] = 1;
        end
        if (m_run_val[k] != m_stable[k] && m_run_len[k] == DEB) begin
          m_stable[k] = m_run_val[k];
          if (m_run_val[k] == 1'b0) exp_mask[t + DEB][k] = 1'b1;
        end
      end
    end
    $display("random keys: %0d cycles, presses key0=%0d key1=%0d key2=%0d", RLEN, n_evt[0], n_evt[1], n_evt[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
